arith_serial: RTL and testbench

//  Bit-serial responder for the 8-bit add/subtract operation (SUM = A +/- B, OV = signed overflow).

---
 rtl/arith_serial_pkg.sv | 16 +
 rtl/arith_serial_fa_cell.sv | 13 +
 rtl/arith_serial.sv | 131 +++++++++++++
 tb/tb_arith_serial.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/arith_serial_pkg.sv
// Shared types and helpers for the bit-serial add/subtract unit.
package arith_serial_pkg;

  localparam int unsigned WIDTH_DEFAULT = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Signed overflow from operand sign bits and the result sign bit.
  function automatic logic ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/arith_serial_fa_cell.sv
// One-bit full adder; the only arithmetic element in the serial datapath.
module arith_serial_fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  assign s_o    = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/arith_serial.sv
// Bit-serial A +/- B with signed overflow; one result bit per clock, LSB first.
module arith_serial
  import arith_serial_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SUB,
  input  logic             strt,
  output logic [WIDTH-1:0] SUM,
  output logic             OV,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-2:0]   res_sh_q, res_sh_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               ov_q, ov_d;
  logic               done_q, done_d;
  logic               s_c;
  logic               cout_c;
  logic               last_c;

  arith_serial_fa_cell u_fa (
    .a_i   (a_sh_q[0]),
    .b_i   (b_sh_q[0]),
    .cin_i (carry_q),
    .s_o   (s_c),
    .cout_o(cout_c)
  );

  assign last_c = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (strt)   state_d = SHIFT;
      SHIFT:   if (last_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values; outputs only move on the completing edge.
  always_comb begin
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    sum_d    = sum_q;
    ov_d     = ov_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (strt) begin
          a_sh_d  = A;
          b_sh_d  = B ^ {WIDTH{SUB}};
          carry_d = SUB;
          cnt_d   = '0;
          a_msb_d = A[WIDTH-1];
          b_msb_d = B[WIDTH-1] ^ SUB;
        end
      end
      SHIFT: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_sh_d = (WIDTH-1)'({s_c, res_sh_q} >> 1);
        carry_d  = cout_c;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_c) begin
          sum_d  = {s_c, res_sh_q};
          ov_d   = ovf(a_msb_q, b_msb_q, s_c);
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      sum_q    <= '0;
      ov_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      sum_q    <= sum_d;
      ov_q     <= ov_d;
      done_q   <= done_d;
    end
  end

  assign SUM  = sum_q;
  assign OV   = ov_q;
  assign done = done_q;
  assign busy = (state_q == SHIFT);

endmodule

// File: tb/tb_arith_serial.sv
// Directed and random checks of arith_serial against hand-computed and integer reference results.
module tb_arith_serial;

  logic       clk;
  logic       rst;
  logic [7:0] A;
  logic [7:0] B;
  logic       SUB;
  logic       strt;
  logic [7:0] SUM;
  logic       OV;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  logic [7:0] prev_sum;
  logic       prev_ov;
  bit         mon_en = 1'b0;

  arith_serial #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .A   (A),
    .B   (B),
    .SUB (SUB),
    .strt(strt),
    .SUM (SUM),
    .OV  (OV),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs must hold still except on the edge that raises done.
  always @(negedge clk) begin
    if (mon_en && !rst && !done) begin
      checks++;
      if (SUM !== prev_sum || OV !== prev_ov) begin
        errors++;
        $display("FAIL stable: SUM=%h OV=%b changed from SUM=%h OV=%b without done", SUM, OV, prev_sum, prev_ov);
      end
    end
    prev_sum = SUM;
    prev_ov  = OV;
  end

  // Launch one op from the current (post-edge) point and wait for done, bounded.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sub,
                        output logic [7:0] sum, output logic ov, output int lat, output bit busy_ok);
    A = a; B = b; SUB = sub; strt = 1'b1;
    @(posedge clk); #1;
    strt = 1'b0;
    A = 8'($urandom); B = 8'($urandom); SUB = 1'($urandom);
    lat = 0;
    busy_ok = 1'b1;
    while (!done && lat < 20) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    sum = SUM;
    ov  = OV;
  endtask

  task automatic test_reset();
    rst = 1'b1; A = '0; B = '0; SUB = 1'b0; strt = 1'b0;
    #12;
    checks++;
    if ({SUM, OV, busy, done} !== 11'h000) begin
      errors++;
      $display("FAIL reset: SUM=%h OV=%b busy=%b done=%b, want 00 0 0 0", SUM, OV, busy, done);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] s; logic o; int lat; bit bok;
    run_op(8'hA5, 8'h5A, 1'b0, s, o, lat, bok);
    checks++;
    if (lat !== 8 || !bok) begin
      errors++;
      $display("FAIL basic_timing: latency=%0d busy_ok=%b, want 8 1", lat, bok);
    end
    checks++;
    if (s !== 8'hFF || o !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: SUM=%h OV=%b, want FF 0", s, o);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_pulse: done=%b busy=%b one cycle later, want 0 0", done, busy);
    end
  endtask

  task automatic test_vectors();
    logic [7:0] va [7] = '{8'hA5, 8'h5A, 8'h5A, 8'h01, 8'h01, 8'h7F, 8'h80};
    logic [7:0] vb [7] = '{8'h5A, 8'h5A, 8'h5A, 8'h80, 8'h80, 8'h7F, 8'h7F};
    logic       vs [7] = '{1'b1,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1};
    logic [7:0] es [7] = '{8'h4B, 8'hB4, 8'h00, 8'h81, 8'h81, 8'hFE, 8'h01};
    logic       eo [7] = '{1'b1,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b1};
    logic [7:0] s; logic o; int lat; bit bok;
    for (int i = 0; i < 7; i++) begin
      run_op(va[i], vb[i], vs[i], s, o, lat, bok);
      checks++;
      if (s !== es[i] || o !== eo[i] || lat !== 8) begin
        errors++;
        $display("FAIL vector%0d: %h %s %h gave SUM=%h OV=%b lat=%0d, want SUM=%h OV=%b lat=8",
                 i, va[i], vs[i] ? "-" : "+", vb[i], s, o, lat, es[i], eo[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] s; logic o; int lat; bit bok;
    int n;
    A = 8'h33; B = 8'h11; SUB = 1'b0; strt = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (!done && n < 20) begin
      if (n < 5) begin
        A = 8'($urandom); B = 8'($urandom); SUB = 1'($urandom);
      end else begin
        strt = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    strt = 1'b0;
    checks++;
    if (SUM !== 8'h44 || OV !== 1'b0 || n !== 8) begin
      errors++;
      $display("FAIL strt_held: SUM=%h OV=%b lat=%0d, want 44 0 8", SUM, OV, n);
    end
    run_op(8'h70, 8'h20, 1'b1, s, o, lat, bok);
    checks++;
    if (s !== 8'h50 || o !== 1'b0 || lat !== 8 || !bok) begin
      errors++;
      $display("FAIL back_to_back: SUM=%h OV=%b lat=%0d busy_ok=%b, want 50 0 8 1", s, o, lat, bok);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    logic [7:0] s; logic o; int lat; bit bok;
    int seen;
    A = 8'h11; B = 8'h22; SUB = 1'b0; strt = 1'b1;
    @(posedge clk); #1;
    strt = 1'b0;
    repeat (2) @(posedge clk);
    #4;
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if ({SUM, OV, busy, done} !== 11'h000) begin
      errors++;
      $display("FAIL abort_reset: SUM=%h OV=%b busy=%b done=%b, want 00 0 0 0", SUM, OV, busy, done);
    end
    #4;
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abort_no_done: done/busy seen in %0d cycles after abort, want 0", seen);
    end
    mon_en = 1'b1;
    run_op(8'h12, 8'h34, 1'b0, s, o, lat, bok);
    checks++;
    if (s !== 8'h46 || o !== 1'b0 || lat !== 8) begin
      errors++;
      $display("FAIL after_abort: SUM=%h OV=%b lat=%0d, want 46 0 8", s, o, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [7:0] a, b, s, es; logic sub, o, eo; int lat; bit bok;
    int r;
    for (int i = 0; i < 2000; i++) begin
      a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
      r = sub ? (int'($signed(a)) - int'($signed(b))) : (int'($signed(a)) + int'($signed(b)));
      es = 8'(r);
      eo = (r > 127) || (r < -128);
      run_op(a, b, sub, s, o, lat, bok);
      checks++;
      if (s !== es || o !== eo || lat !== 8 || !bok) begin
        errors++;
        $display("FAIL random%0d: %h %s %h gave SUM=%h OV=%b lat=%0d, want SUM=%h OV=%b lat=8",
                 i, a, sub ? "-" : "+", b, s, o, lat, es, eo);
      end
      if ($urandom_range(1, 0) == 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_back_to_back();
    test_reset_abort();
    test_random();
    @(posedge clk); #1;
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
